// File: rtl/rf_param_if.sv
// Bundle of the register-file control, write, read and scoreboard signals.
// The slave side is the register file; the master side is the pipeline driving it.
interface rf_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              clr_req;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] reg_address_1;
  logic [ADDR_W-1:0] reg_address_2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_address;
  logic              busy1;
  logic              busy2;

  modport master (
    output clr_req, we, write_address, data, reg_address_1, reg_address_2,
           alloc_en, alloc_address,
    input  ready, rd1, rd2, busy1, busy2
  );

  modport slave (
    input  clr_req, we, write_address, data, reg_address_1, reg_address_2,
           alloc_en, alloc_address,
    output ready, rd1, rd2, busy1, busy2
  );
endinterface

// File: rtl/rf_param.sv
// Parametrised 2-read/1-write register file with a clear sweep after reset or on
// request, an optional hardwired zero register, write bypass and a pending scoreboard.
module rf_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset,
  rf_param_if.slave    bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_nextState;
  logic [ADDR_W-1:0] r_clrPtr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pending;

  logic w_ready;
  logic w_doWrite;
  logic w_doAlloc;
  logic w_wrZero;
  logic w_zero1;
  logic w_zero2;
  logic w_hit1;
  logic w_hit2;

  assign w_ready   = (r_state == READY);
  assign w_wrZero  = (ZERO_REG != 0) && (bus.write_address == '0);
  assign w_doWrite = w_ready && !bus.clr_req && bus.we;
  assign w_doAlloc = w_ready && !bus.clr_req && bus.alloc_en &&
                     !((ZERO_REG != 0) && (bus.alloc_address == '0));

  assign w_zero1 = (ZERO_REG != 0) && (bus.reg_address_1 == '0);
  assign w_zero2 = (ZERO_REG != 0) && (bus.reg_address_2 == '0);
  assign w_hit1  = (BYPASS != 0) && bus.we && (bus.write_address == bus.reg_address_1);
  assign w_hit2  = (BYPASS != 0) && bus.we && (bus.write_address == bus.reg_address_2);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      CLEAR:   if (&r_clrPtr) w_nextState = READY;
      READY:   if (bus.clr_req) w_nextState = CLEAR;
      default: w_nextState = CLEAR;
    endcase
  end

  // The sweep pointer wraps back to 0 on the last cleared index, ready for the next sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clrPtr  <= '0;
      r_pending <= '0;
    end else begin
      r_state <= w_nextState;
      if (!w_ready) begin
        r_clrPtr <= r_clrPtr + 1'b1;
      end else if (bus.clr_req) begin
        r_clrPtr  <= '0;
        r_pending <= '0;
      end else begin
        if (w_doWrite) r_pending[bus.write_address] <= 1'b0;
        if (w_doAlloc) r_pending[bus.alloc_address] <= 1'b1;
      end
    end
  end

  // The array itself is never reset; only the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!w_ready) begin
        r_mem[r_clrPtr] <= '0;
      end else if (w_doWrite && !w_wrZero) begin
        r_mem[bus.write_address] <= bus.data;
      end
    end
  end

  always_comb begin
    bus.ready = w_ready;
    bus.rd1   = '0;
    bus.rd2   = '0;
    if (w_ready && !w_zero1) bus.rd1 = w_hit1 ? bus.data : r_mem[bus.reg_address_1];
    if (w_ready && !w_zero2) bus.rd2 = w_hit2 ? bus.data : r_mem[bus.reg_address_2];
    bus.busy1 = w_ready && !w_zero1 && r_pending[bus.reg_address_1] && !w_hit1;
    bus.busy2 = w_ready && !w_zero2 && r_pending[bus.reg_address_2] && !w_hit2;
  end
endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param: a bypassing and a non-bypassing build share one stimulus stream
// and are compared every cycle against a behavioural model of the register file.
module tb_rf_param;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk;
  logic reset;
  logic checkEn;
  int   compared;
  int   mismatched;

  rf_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifA ();
  rf_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifB ();

  rf_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA.slave)
  );

  rf_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB.slave)
  );

  assign ifB.clr_req       = ifA.clr_req;
  assign ifB.we            = ifA.we;
  assign ifB.write_address = ifA.write_address;
  assign ifB.data          = ifA.data;
  assign ifB.reg_address_1 = ifA.reg_address_1;
  assign ifB.reg_address_2 = ifA.reg_address_2;
  assign ifB.alloc_en      = ifA.alloc_en;
  assign ifB.alloc_address = ifA.alloc_address;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: register contents, pending set, and how far the clear sweep has got.
  logic [DATA_W-1:0] modelMem [DEPTH];
  logic [DEPTH-1:0]  modelPending;
  logic              modelReady;
  int                sweepCount;

  initial begin
    modelReady   = 1'b0;
    sweepCount   = 0;
    modelPending = '0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
  end

  always @(posedge clk) begin
    if (reset) begin
      modelReady   <= 1'b0;
      sweepCount   <= 0;
      modelPending <= '0;
    end else if (!modelReady) begin
      modelMem[sweepCount] <= '0;
      if (sweepCount == DEPTH - 1) modelReady <= 1'b1;
      sweepCount <= (sweepCount + 1) % DEPTH;
    end else if (ifA.clr_req) begin
      modelReady   <= 1'b0;
      sweepCount   <= 0;
      modelPending <= '0;
    end else begin
      if (ifA.we && ifA.write_address != 0) modelMem[ifA.write_address] <= ifA.data;
      if (ifA.we) modelPending[ifA.write_address] <= 1'b0;
      if (ifA.alloc_en && ifA.alloc_address != 0) modelPending[ifA.alloc_address] <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] expRead(input logic [ADDR_W-1:0] addr, input bit bypass);
    if (addr == 0 || !modelReady) return '0;
    if (bypass && ifA.we && ifA.write_address == addr) return ifA.data;
    return modelMem[addr];
  endfunction

  function automatic logic expBusy(input logic [ADDR_W-1:0] addr, input bit bypass);
    if (addr == 0 || !modelReady) return 1'b0;
    return modelPending[addr] && !(bypass && ifA.we && ifA.write_address == addr);
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("readyA", 32'(ifA.ready), 32'(modelReady));
      checkOutput("rd1A",   ifA.rd1, expRead(ifA.reg_address_1, 1'b1));
      checkOutput("rd2A",   ifA.rd2, expRead(ifA.reg_address_2, 1'b1));
      checkOutput("busy1A", 32'(ifA.busy1), 32'(expBusy(ifA.reg_address_1, 1'b1)));
      checkOutput("busy2A", 32'(ifA.busy2), 32'(expBusy(ifA.reg_address_2, 1'b1)));
      checkOutput("readyB", 32'(ifB.ready), 32'(modelReady));
      checkOutput("rd1B",   ifB.rd1, expRead(ifA.reg_address_1, 1'b0));
      checkOutput("rd2B",   ifB.rd2, expRead(ifA.reg_address_2, 1'b0));
      checkOutput("busy1B", 32'(ifB.busy1), 32'(expBusy(ifA.reg_address_1, 1'b0)));
      checkOutput("busy2B", 32'(ifB.busy2), 32'(expBusy(ifA.reg_address_2, 1'b0)));
    end
  end

  task automatic applyStimulus(input logic c, input logic w, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a1,
                               input logic [ADDR_W-1:0] a2, input logic al,
                               input logic [ADDR_W-1:0] aa);
    ifA.clr_req       = c;
    ifA.we            = w;
    ifA.write_address = wa;
    ifA.data          = d;
    ifA.reg_address_1 = a1;
    ifA.reg_address_2 = a2;
    ifA.alloc_en      = al;
    ifA.alloc_address = aa;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic sweepAndCheck(input string name);
    for (int i = 1; i <= DEPTH; i++) begin
      stepClock();
      checkOutput(name, 32'(ifA.ready), 32'(i == DEPTH));
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    checkEn    = 1'b0;
    reset      = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepClock();
    stepClock();
    checkEn = 1'b1;
    checkOutput("resetReady", 32'(ifA.ready), 32'd0);
    reset = 1'b0;
    sweepAndCheck("sweepReady");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 5'(i * 4 + 1), 5'(i * 4 + 2), 0, 0);
      #1;
      checkOutput("sweptZero", ifA.rd1, 32'h0);
    end

    applyStimulus(0, 1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7, 0, 0);
    #1;
    checkOutput("bypassRd1", ifA.rd1, 32'hDEADBEEF);
    checkOutput("noBypassRd2", ifB.rd2, 32'h0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 5'd7, 5'd7, 0, 0);
    #1;
    checkOutput("arrayRd1", ifA.rd1, 32'hDEADBEEF);
    checkOutput("arrayRd2B", ifB.rd2, 32'hDEADBEEF);

    applyStimulus(0, 1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1, 5'd0);
    #1;
    checkOutput("zeroRd2", ifA.rd2, 32'h0);
    checkOutput("zeroBusy2", 32'(ifA.busy2), 32'd0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 0, 0);
    #1;
    checkOutput("zeroRd2After", ifA.rd2, 32'h0);
    checkOutput("zeroBusy2After", 32'(ifA.busy2), 32'd0);

    applyStimulus(0, 0, 0, 0, 5'd3, 5'd3, 1, 5'd3);
    stepClock();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 5'd3, 5'd3, 0, 0);
      #1;
      checkOutput("allocBusy1", 32'(ifA.busy1), 32'd1);
      stepClock();
    end
    applyStimulus(0, 1, 5'd3, 32'h55, 5'd3, 5'd3, 0, 0);
    #1;
    checkOutput("bypassBusy1", 32'(ifA.busy1), 32'd0);
    checkOutput("noBypassBusy1", 32'(ifB.busy1), 32'd1);
    stepClock();
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd3, 0, 0);
    #1;
    checkOutput("writtenBusy1", 32'(ifA.busy1), 32'd0);
    checkOutput("writtenRd1", ifA.rd1, 32'h55);

    applyStimulus(0, 1, 5'd9, 32'h99, 5'd9, 5'd9, 1, 5'd9);
    stepClock();
    applyStimulus(0, 0, 0, 0, 5'd9, 5'd9, 0, 0);
    #1;
    checkOutput("allocWinsBusy2", 32'(ifA.busy2), 32'd1);
    checkOutput("allocWriteRd2", ifA.rd2, 32'h99);

    for (int r = 1; r <= 4; r++) begin
      applyStimulus(0, 1, 5'(r), 32'hA0 + 32'(r), 0, 0, 0, 0);
      stepClock();
    end
    applyStimulus(1, 1, 5'd2, 32'hBAD, 0, 0, 1, 5'd2);
    stepClock();
    checkOutput("clrReady", 32'(ifA.ready), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 4)), $urandom, 0, 0, 0, 0);
      stepClock();
      checkOutput("clrSweepReady", 32'(ifA.ready), 32'(i == DEPTH));
    end
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(0, 0, 0, 0, 5'(r), 5'd9, 0, 0);
      #1;
      checkOutput("clearedRd1", ifA.rd1, 32'h0);
      checkOutput("clearedBusy2", 32'(ifA.busy2), 32'd0);
    end

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    stepClock();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) stepClock();
    reset = 1'b1;
    stepClock();
    reset = 1'b0;
    sweepAndCheck("midSweepReady");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)));
      reset = ($urandom_range(0, 399) == 0);
      stepClock();
    end
    reset = 1'b0;
    stepClock();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
